// File: rtl/mux_4_rr_arb_pkg.sv
// Shared constants and types for the four-source round-robin arbiter/mux.
// Holds the source count, the source index width and the output FSM state
// encoding, plus a small helper for wrapping source-index arithmetic.
package mux_4_rr_arb_pkg;

    localparam int SRC_W   = 2;
    localparam int NUM_SRC = 4;

    // EMPTY: output register holds no beat (out_valid=0).
    // FULL : output register holds a beat awaiting out_ready.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    // Next source index after i, wrapping 3 -> 0 by natural overflow.
    function automatic logic [SRC_W-1:0] next_idx(input logic [SRC_W-1:0] i);
        return i + SRC_W'(1);
    endfunction

endpackage

// File: rtl/mux_4_rr_arb_mux_4_sel.sv
// Purpose: purely combinational BUS_WIDTH-wide 4:1 multiplexer.
// Latency: zero cycles, output follows sel and inputs combinationally.
// Backpressure: none; no state, no handshake.
//
// Ports:
//   sel            - source index to steer to out_data
//   in_data_0..3   - candidate data buses
//   out_data       - selected bus
module mux_4_sel
    import mux_4_rr_arb_pkg::*;
#(
    parameter int BUS_WIDTH = 8
) (
    input  logic [SRC_W-1:0]     sel,
    input  logic [BUS_WIDTH-1:0] in_data_0,
    input  logic [BUS_WIDTH-1:0] in_data_1,
    input  logic [BUS_WIDTH-1:0] in_data_2,
    input  logic [BUS_WIDTH-1:0] in_data_3,
    output logic [BUS_WIDTH-1:0] out_data
);

    always_comb begin
        out_data = in_data_0;
        case (sel)
            2'd0:    out_data = in_data_0;
            2'd1:    out_data = in_data_1;
            2'd2:    out_data = in_data_2;
            2'd3:    out_data = in_data_3;
            default: out_data = in_data_0;
        endcase
    end

endmodule

// File: rtl/mux_4_rr_arb.sv
// Purpose: round-robin arbiter sharing one 4:1 mux between four valid/ready
//          sources, feeding a single registered output channel.
// Latency: one cycle from in_valid&in_ready to out_valid/out_data.
// Backpressure: out_ready=0 while FULL holds the beat and drops all in_ready;
//          a pop and a new load may happen in the same cycle (no bubble).
//
// Ports:
//   clk, rst_n       - clock and synchronous active-low reset
//   in_valid[3:0]    - per-source valid, bit i qualifies in_data_i
//   in_data_0..3     - per-source data
//   in_ready[3:0]    - one-hot (or zero) accept strobe to the sources
//   out_valid        - output register holds a beat
//   out_data         - registered selected data
//   out_src          - index of the source that produced out_data
//   out_ready        - consumer accepts the beat when high with out_valid
module mux_4_rr_arb
    import mux_4_rr_arb_pkg::*;
#(
    parameter int BUS_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           in_valid,
    input  logic [BUS_WIDTH-1:0] in_data_0,
    input  logic [BUS_WIDTH-1:0] in_data_1,
    input  logic [BUS_WIDTH-1:0] in_data_2,
    input  logic [BUS_WIDTH-1:0] in_data_3,
    output logic [3:0]           in_ready,
    output logic                 out_valid,
    output logic [BUS_WIDTH-1:0] out_data,
    output logic [1:0]           out_src,
    input  logic                 out_ready
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e                 state_q,    state_d;
    logic [SRC_W-1:0]       ptr_q,      ptr_d;      // highest-priority source
    logic [BUS_WIDTH-1:0]   out_data_q, out_data_d;
    logic [SRC_W-1:0]       out_src_q,  out_src_d;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic                   load_en;
    logic                   any_req;
    logic [SRC_W-1:0]       gnt;
    logic [SRC_W-1:0]       scan_idx;
    logic                   found;
    logic [BUS_WIDTH-1:0]   mux_data;

    // The register can take a new beat when empty, or when the held beat
    // is leaving this cycle.
    assign load_en = (state_q == EMPTY) || out_ready;
    assign any_req = |in_valid;

    // Rotating priority scan: ptr, ptr+1, ptr+2, ptr+3 (mod 4). The first
    // valid source wins. When nothing is valid gnt is a don't-care.
    always_comb begin
        gnt      = ptr_q;
        found    = 1'b0;
        scan_idx = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            scan_idx = ptr_q + SRC_W'(k);
            if (!found && in_valid[scan_idx]) begin
                gnt   = scan_idx;
                found = 1'b1;
            end
        end
    end

    // Accept strobe goes to the granted source only. Gating with rst_n keeps
    // any handshake from completing on a reset edge, where the beat would
    // otherwise be lost.
    always_comb begin
        in_ready = '0;
        if (rst_n && load_en && any_req) begin
            in_ready[gnt] = 1'b1;
        end
    end

    mux_4_sel #(
        .BUS_WIDTH (BUS_WIDTH)
    ) u_mux (
        .sel       (gnt),
        .in_data_0 (in_data_0),
        .in_data_1 (in_data_1),
        .in_data_2 (in_data_2),
        .in_data_3 (in_data_3),
        .out_data  (mux_data)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        out_data_d = out_data_q;
        out_src_d  = out_src_q;

        if (load_en) begin
            if (any_req) begin
                state_d    = FULL;
                out_data_d = mux_data;
                out_src_d  = gnt;
                // The winner drops to lowest priority next round.
                ptr_d      = next_idx(gnt);
            end else begin
                // Data and source are left as-is so a consumer peeking at
                // out_data after the pop still sees the last beat.
                state_d    = EMPTY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            ptr_q      <= '0;
            out_data_q <= '0;
            out_src_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            out_data_q <= out_data_d;
            out_src_q  <= out_src_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out_valid = (state_q == FULL);
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_mux_4_rr_arb.sv
module tb_mux_4_rr_arb;

    localparam int BW = 8;

    logic          clk;
    logic          rst_n;
    logic [3:0]    in_valid;
    logic [BW-1:0] in_data_0;
    logic [BW-1:0] in_data_1;
    logic [BW-1:0] in_data_2;
    logic [BW-1:0] in_data_3;
    logic [3:0]    in_ready;
    logic          out_valid;
    logic [BW-1:0] out_data;
    logic [1:0]    out_src;
    logic          out_ready;

    int tests_run;
    int tests_failed;

    mux_4_rr_arb #(.BUS_WIDTH(BW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data_0 (in_data_0),
        .in_data_1 (in_data_1),
        .in_data_2 (in_data_2),
        .in_data_3 (in_data_3),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reset held for two edges with every source requesting; afterwards
    // source 0 must be the first offered a grant.
    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        in_data_0 = 8'hA0;
        in_data_1 = 8'hA1;
        in_data_2 = 8'hA2;
        in_data_3 = 8'hA3;
        out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            @(negedge clk);
            tests_run++;
            if (in_ready !== 4'b0000) begin
                tests_failed++;
                $display("FAIL reset_in_ready cyc%0d: got %b want 0000", c, in_ready);
            end
            tests_run++;
            if (out_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_out_valid cyc%0d: got %b want 0", c, out_valid);
            end
            tests_run++;
            if (out_data !== 8'h00) begin
                tests_failed++;
                $display("FAIL reset_out_data cyc%0d: got %h want 00", c, out_data);
            end
            tests_run++;
            if (out_src !== 2'd0) begin
                tests_failed++;
                $display("FAIL reset_out_src cyc%0d: got %0d want 0", c, out_src);
            end
        end
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 4'b0001) begin
            tests_failed++;
            $display("FAIL reset_release_ready: got %b want 0001", in_ready);
        end
        // Withdraw before the edge so nothing is accepted.
        in_valid = 4'b0000;
    endtask

    // All four requesting, consumer always ready: 0,1,2,3,0 back to back.
    task automatic test_round_robin();
        logic [1:0]    exp_src;
        logic [3:0]    exp_rdy;
        logic [BW-1:0] exp_dat;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 4'b0001) begin
            tests_failed++;
            $display("FAIL rr_first_ready: got %b want 0001", in_ready);
        end
        for (int i = 0; i < 5; i++) begin
            exp_src = 2'(i % 4);
            exp_dat = 8'hA0 + 8'(i % 4);
            exp_rdy = 4'b0001 << ((i + 1) % 4);
            @(negedge clk);
            tests_run++;
            if (out_valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL rr_valid beat%0d: got %b want 1", i, out_valid);
            end
            tests_run++;
            if (out_src !== exp_src) begin
                tests_failed++;
                $display("FAIL rr_src beat%0d: got %0d want %0d", i, out_src, exp_src);
            end
            tests_run++;
            if (out_data !== exp_dat) begin
                tests_failed++;
                $display("FAIL rr_data beat%0d: got %h want %h", i, out_data, exp_dat);
            end
            tests_run++;
            if (in_ready !== exp_rdy) begin
                tests_failed++;
                $display("FAIL rr_ready beat%0d: got %b want %b", i, in_ready, exp_rdy);
            end
        end
        in_valid = 4'b0000;
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rr_empty: got %b want 0", out_valid);
        end
    endtask

    // Source 2 alone, consumer stalls five cycles, then a pop and a new load
    // land on the same edge.
    task automatic test_backpressure();
        out_ready = 1'b0;
        in_data_2 = 8'h5C;
        in_valid  = 4'b0100;
        #1;
        tests_run++;
        if (in_ready !== 4'b0100) begin
            tests_failed++;
            $display("FAIL bp_first_ready: got %b want 0100", in_ready);
        end
        @(posedge clk);
        #1;
        in_data_2 = 8'h5D;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            tests_run++;
            if (out_valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL bp_valid cyc%0d: got %b want 1", j, out_valid);
            end
            tests_run++;
            if (out_data !== 8'h5C) begin
                tests_failed++;
                $display("FAIL bp_data cyc%0d: got %h want 5c", j, out_data);
            end
            tests_run++;
            if (out_src !== 2'd2) begin
                tests_failed++;
                $display("FAIL bp_src cyc%0d: got %0d want 2", j, out_src);
            end
            tests_run++;
            if (in_ready !== 4'b0000) begin
                tests_failed++;
                $display("FAIL bp_ready cyc%0d: got %b want 0000", j, in_ready);
            end
        end
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 4'b0100) begin
            tests_failed++;
            $display("FAIL bp_release_ready: got %b want 0100", in_ready);
        end
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 8'h5D) begin
            tests_failed++;
            $display("FAIL bp_next_beat: got valid=%b data=%h want valid=1 data=5d", out_valid, out_data);
        end
        in_valid = 4'b0000;
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_empty: got %b want 0", out_valid);
        end
    endtask

    // ptr=3 on entry, sources 0 and 2 requesting: grants 0,2,0.
    task automatic test_wrap_skip();
        logic [3:0] exp_rdy [3];
        logic [1:0] exp_src [3];
        logic [7:0] exp_dat [3];
        exp_rdy[0] = 4'b0001; exp_src[0] = 2'd0; exp_dat[0] = 8'h10;
        exp_rdy[1] = 4'b0100; exp_src[1] = 2'd2; exp_dat[1] = 8'h12;
        exp_rdy[2] = 4'b0001; exp_src[2] = 2'd0; exp_dat[2] = 8'h10;
        out_ready = 1'b1;
        in_data_0 = 8'h10;
        in_data_2 = 8'h12;
        in_valid  = 4'b0101;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++;
            if (in_ready !== exp_rdy[i]) begin
                tests_failed++;
                $display("FAIL wrap_ready g%0d: got %b want %b", i, in_ready, exp_rdy[i]);
            end
            @(negedge clk);
            tests_run++;
            if (out_src !== exp_src[i] || out_data !== exp_dat[i]) begin
                tests_failed++;
                $display("FAIL wrap_out g%0d: got src=%0d data=%h want src=%0d data=%h",
                         i, out_src, out_data, exp_src[i], exp_dat[i]);
            end
        end
        in_valid = 4'b0000;
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL wrap_empty: got %b want 0", out_valid);
        end
    endtask

    // Single beat from source 1: valid for exactly one cycle, data held after.
    task automatic test_drain();
        out_ready = 1'b1;
        in_data_1 = 8'h77;
        in_valid  = 4'b0010;
        #1;
        tests_run++;
        if (in_ready !== 4'b0010) begin
            tests_failed++;
            $display("FAIL drain_ready: got %b want 0010", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 4'b0000;
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b1 || out_src !== 2'd1 || out_data !== 8'h77) begin
            tests_failed++;
            $display("FAIL drain_beat: got v=%b src=%0d data=%h want v=1 src=1 data=77",
                     out_valid, out_src, out_data);
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            tests_run++;
            if (out_valid !== 1'b0 || out_src !== 2'd1 || out_data !== 8'h77) begin
                tests_failed++;
                $display("FAIL drain_hold cyc%0d: got v=%b src=%0d data=%h want v=0 src=1 data=77",
                         c, out_valid, out_src, out_data);
            end
        end
    endtask

    // ptr=2 on entry; source 1 loads, consumer stalls, reset hits. The held
    // beat vanishes and source 0 wins next (proves ptr returned to 0).
    task automatic test_reset_midstream();
        out_ready = 1'b0;
        in_data_0 = 8'hA0;
        in_data_1 = 8'h99;
        in_valid  = 4'b0010;
        @(posedge clk);
        #1;
        in_valid = 4'b1111;
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b1 || out_src !== 2'd1 || out_data !== 8'h99 || in_ready !== 4'b0000) begin
            tests_failed++;
            $display("FAIL mid_full: got v=%b src=%0d data=%h rdy=%b want v=1 src=1 data=99 rdy=0000",
                     out_valid, out_src, out_data, in_ready);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (in_ready !== 4'b0000) begin
            tests_failed++;
            $display("FAIL mid_rst_ready: got %b want 0000", in_ready);
        end
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_src !== 2'd0) begin
            tests_failed++;
            $display("FAIL mid_after_rst: got v=%b data=%h src=%0d want v=0 data=00 src=0",
                     out_valid, out_data, out_src);
        end
        tests_run++;
        if (in_ready !== 4'b0001) begin
            tests_failed++;
            $display("FAIL mid_ptr_zero: got %b want 0001", in_ready);
        end
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b1 || out_src !== 2'd0 || out_data !== 8'hA0) begin
            tests_failed++;
            $display("FAIL mid_first_beat: got v=%b src=%0d data=%h want v=1 src=0 data=a0",
                     out_valid, out_src, out_data);
        end
        in_valid = 4'b0000;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_round_robin();
        test_backpressure();
        test_wrap_skip();
        test_drain();
        test_reset_midstream();
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
